id_stage_hs: RTL and testbench

- Parametrised next-generation decode stage with the ID/EX pipeline register folded in.
- Decodes the instruction, reads a parametrised register file with optional WB-to-ID bypass, and generates the immediate.
- Holds a registered decoded bundle behind a valid/ready handshake.
- Detects load-use hazards internally and supports flush.
- Sits between the IF/ID register and the EX stage.

---
 rtl/id_stage_hs_if.sv | 68 ++++++
 rtl/id_stage_hs.sv | 247 ++++++++++++++++++++++++
 tb/tb_id_stage_hs.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_hs_if.sv
// Pipeline ports of the decode stage: the IF/ID-side instruction handshake and
// the registered ID/EX bundle with its handshake.
// The master modport is the decode stage itself; the slave modport is the
// surrounding pipeline (IF/ID register upstream, EX stage downstream).
interface id_stage_hs_if #(
    parameter int unsigned XLEN = 32
);
    // IF/ID side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;

    // ID/EX side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic            out_illegal;

    modport master (
        input  in_valid,
        input  instruction,
        input  pc,
        output in_ready,
        input  out_ready,
        output out_valid,
        output out_pc,
        output out_rs1_data,
        output out_rs2_data,
        output out_imm,
        output out_rs1,
        output out_rs2,
        output out_rd,
        output out_opcode,
        output out_funct3,
        output out_funct7,
        output out_illegal
    );

    modport slave (
        output in_valid,
        output instruction,
        output pc,
        input  in_ready,
        output out_ready,
        input  out_valid,
        input  out_pc,
        input  out_rs1_data,
        input  out_rs2_data,
        input  out_imm,
        input  out_rs1,
        input  out_rs2,
        input  out_rd,
        input  out_opcode,
        input  out_funct3,
        input  out_funct7,
        input  out_illegal
    );
endinterface

// File: rtl/id_stage_hs.sv
// id_stage_hs: RV32I/RV32E decode stage with the ID/EX register folded in.
// Decodes fields and immediates, reads the register file (optionally bypassing
// a same-cycle WB write), stalls one cycle on a load-use hazard against the
// bundle it currently holds, and presents the result behind valid/ready.
module id_stage_hs #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            reg_write_wb,
    input  logic [4:0]      rd_wb,
    input  logic [XLEN-1:0] write_data_wb,
    id_stage_hs_if.master   bus
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef enum logic [2:0] {
        FmtR,
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtBad
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } bundle_t;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign instr  = bus.instruction;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    fmt_e            fmt;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            uses_rd;
    logic [XLEN-1:0] imm;

    // Classify the opcode and derive which register fields are real operands.
    always_comb begin
        fmt = FmtBad;
        case (opcode)
            OpReg:                 fmt = FmtR;
            OpLoad, OpImm, OpJalr: fmt = FmtI;
            OpStore:               fmt = FmtS;
            OpBranch:              fmt = FmtB;
            OpLui, OpAuipc:        fmt = FmtU;
            OpJal:                 fmt = FmtJ;
            default:               fmt = FmtBad;
        endcase
        uses_rs1 = (fmt != FmtU) && (fmt != FmtJ);
        uses_rs2 = (fmt == FmtR) || (fmt == FmtS) || (fmt == FmtB);
        uses_rd  = (fmt != FmtS) && (fmt != FmtB);
    end

    // Build the sign-extended immediate; R-type and unknown opcodes give zero.
    always_comb begin
        imm = '0;
        case (fmt)
            FmtI: imm = XLEN'($signed(instr[31:20]));
            FmtS: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FmtB: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            FmtU: imm = XLEN'($signed({instr[31:12], 12'b0}));
            FmtJ: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NUM_REGS];
    logic [XLEN-1:0] rf_d [NUM_REGS];
    logic            rs1_in_range;
    logic            rs2_in_range;
    logic            rd_in_range;
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            byp_rs1;
    logic            byp_rs2;

    assign rs1_in_range = (32'(rs1) < NUM_REGS);
    assign rs2_in_range = (32'(rs2) < NUM_REGS);
    assign rd_in_range  = (32'(rd) < NUM_REGS);

    // WB write; x0 is never written and out-of-range destinations are dropped.
    always_comb begin
        rf_d = rf_q;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (reg_write_wb && (rd_wb == 5'(i))) begin
                rf_d[i] = write_data_wb;
            end
        end
    end

    // Register-file state; flush does not block WB writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Read ports: out-of-range indices match no entry and read as zero.
    always_comb begin
        rs1_rf = '0;
        rs2_rf = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rs1 == 5'(i)) rs1_rf = rf_q[i];
            if (rs2 == 5'(i)) rs2_rf = rf_q[i];
        end
    end

    // Same-cycle WB bypass; a nonexistent register is never forwarded.
    always_comb begin
        byp_rs1  = (WB_BYPASS != 0) && reg_write_wb && (rd_wb != 5'd0) &&
                   (rd_wb == rs1) && rs1_in_range;
        byp_rs2  = (WB_BYPASS != 0) && reg_write_wb && (rd_wb != 5'd0) &&
                   (rd_wb == rs2) && rs2_in_range;
        rs1_data = byp_rs1 ? write_data_wb : rs1_rf;
        rs2_data = byp_rs2 ? write_data_wb : rs2_rf;
    end

    // ------------------------------------------------------------------
    // ID/EX register and handshake
    // ------------------------------------------------------------------
    bundle_t dec_bundle;
    bundle_t out_q;
    bundle_t out_d;
    logic    out_valid_q;
    logic    out_valid_d;
    logic    hazard;
    logic    in_ready;
    logic    accept;

    // Assemble the decoded bundle; only fields that name real operands can
    // flag an out-of-range register.
    always_comb begin
        dec_bundle          = '0;
        dec_bundle.pc       = bus.pc;
        dec_bundle.rs1_data = rs1_data;
        dec_bundle.rs2_data = rs2_data;
        dec_bundle.imm      = imm;
        dec_bundle.rs1      = rs1;
        dec_bundle.rs2      = rs2;
        dec_bundle.rd       = rd;
        dec_bundle.opcode   = opcode;
        dec_bundle.funct3   = funct3;
        dec_bundle.funct7   = funct7;
        dec_bundle.illegal  = (fmt == FmtBad) ||
                              (uses_rs1 && !rs1_in_range) ||
                              (uses_rs2 && !rs2_in_range) ||
                              (uses_rd && !rd_in_range);
    end

    // Load-use detection against the held bundle, plus the input handshake.
    always_comb begin
        hazard   = out_valid_q && (out_q.opcode == OpLoad) && (out_q.rd != 5'd0) &&
                   bus.in_valid &&
                   ((uses_rs1 && (rs1 == out_q.rd)) || (uses_rs2 && (rs2 == out_q.rd)));
        in_ready = flush || ((!out_valid_q || bus.out_ready) && !hazard);
        accept   = bus.in_valid && in_ready && !flush;
    end

    // Next state of the output register: load on accept, drop on flush or
    // drain, otherwise hold everything stable.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = dec_bundle;
        end else if (flush || (out_valid_q && bus.out_ready)) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_q.pc;
    assign bus.out_rs1_data = out_q.rs1_data;
    assign bus.out_rs2_data = out_q.rs2_data;
    assign bus.out_imm      = out_q.imm;
    assign bus.out_rs1      = out_q.rs1;
    assign bus.out_rs2      = out_q.rs2;
    assign bus.out_rd       = out_q.rd;
    assign bus.out_opcode   = out_q.opcode;
    assign bus.out_funct3   = out_q.funct3;
    assign bus.out_funct7   = out_q.funct7;
    assign bus.out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs: two instances share one stimulus stream,
// A = (32 regs, bypass on) and B = (16 regs, bypass off), both checked every
// cycle against a transaction-level reference model, plus directed scenarios.
module tb_id_stage_hs;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] instr;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    id_stage_hs_if #(.XLEN(32)) if_a ();
    id_stage_hs_if #(.XLEN(32)) if_b ();

    assign if_a.in_valid    = in_valid;
    assign if_a.instruction = instr;
    assign if_a.pc          = pc;
    assign if_a.out_ready   = out_ready;
    assign if_b.in_valid    = in_valid;
    assign if_b.instruction = instr;
    assign if_b.pc          = pc;
    assign if_b.out_ready   = out_ready;

    id_stage_hs #(.XLEN(32), .NUM_REGS(32), .WB_BYPASS(1)) dut_a (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .reg_write_wb  (wb_we),
        .rd_wb         (wb_rd),
        .write_data_wb (wb_data),
        .bus           (if_a.master)
    );

    id_stage_hs #(.XLEN(32), .NUM_REGS(16), .WB_BYPASS(0)) dut_b (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .reg_write_wb  (wb_we),
        .rd_wb         (wb_rd),
        .write_data_wb (wb_data),
        .bus           (if_b.master)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers per instance and the
    // transaction currently held in the ID/EX register.
    logic [31:0] regs [2][32];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_d1 [2];
    logic [31:0] m_d2 [2];
    logic        m_ill [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nregs(input int c);
        return (c == 0) ? 32 : 16;
    endfunction

    function automatic bit uses1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic bit uses2(input logic [6:0] op);
        return op == OP_REG || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic bit known(input logic [6:0] op);
        return op inside {OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH,
                          OP_LUI, OP_AUIPC, OP_JAL, OP_REG};
    endfunction

    // Immediate from the ISA bit layout, built with signed arithmetic.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int s;
        s = $signed(ins);
        case (ins[6:0])
            OP_LOAD, OP_IMM, OP_JALR: return 32'(s >>> 20);
            OP_STORE:  return 32'((s >>> 25) * 32 + int'(ins[11:7]));
            OP_BRANCH: return 32'((s >>> 31) * 4096 + int'(ins[7]) * 2048 +
                                  int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
            OP_LUI, OP_AUIPC: return ins & 32'hFFFF_F000;
            OP_JAL:    return 32'((s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 +
                                  int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            default:   return 32'h0;
        endcase
    endfunction

    function automatic logic ref_illegal(input int c, input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (!known(op)) return 1'b1;
        if (uses1(op) && int'(ins[19:15]) >= nregs(c)) return 1'b1;
        if (uses2(op) && int'(ins[24:20]) >= nregs(c)) return 1'b1;
        if (!(op == OP_STORE || op == OP_BRANCH) && int'(ins[11:7]) >= nregs(c)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_read(input int c, input logic [4:0] idx);
        if (int'(idx) >= nregs(c)) return 32'h0;
        if (c == 0 && wb_we && wb_rd != 5'd0 && wb_rd == idx) return wb_data;
        return regs[c][idx];
    endfunction

    function automatic logic exp_ready();
        logic hz;
        hz = m_valid && (m_instr[6:0] == OP_LOAD) && (m_instr[11:7] != 5'd0) && in_valid &&
             ((uses1(instr[6:0]) && instr[19:15] == m_instr[11:7]) ||
              (uses2(instr[6:0]) && instr[24:20] == m_instr[11:7]));
        return flush || ((!m_valid || out_ready) && !hz);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) regs[c][r] = 32'h0;
            m_d1[c]  = 32'h0;
            m_d2[c]  = 32'h0;
            m_ill[c] = 1'b0;
        end
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_pc    = 32'h0;
    endtask

    task automatic model_step();
        logic acc;
        if (rst) begin
            model_reset();
            return;
        end
        acc = in_valid && exp_ready() && !flush;
        if (acc) begin
            m_valid = 1'b1;
            m_instr = instr;
            m_pc    = pc;
            for (int c = 0; c < 2; c++) begin
                m_d1[c]  = ref_read(c, instr[19:15]);
                m_d2[c]  = ref_read(c, instr[24:20]);
                m_ill[c] = ref_illegal(c, instr);
            end
        end else if (flush || (m_valid && out_ready)) begin
            m_valid = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            if (wb_we && wb_rd != 5'd0 && int'(wb_rd) < nregs(c)) regs[c][wb_rd] = wb_data;
        end
    endtask

    task automatic compare();
        logic r;
        r = exp_ready();
        check("a.in_ready", 32'(if_a.in_ready), 32'(r));
        check("b.in_ready", 32'(if_b.in_ready), 32'(r));
        check("a.out_valid", 32'(if_a.out_valid), 32'(m_valid));
        check("b.out_valid", 32'(if_b.out_valid), 32'(m_valid));
        check("a.out_pc", if_a.out_pc, m_pc);
        check("a.out_imm", if_a.out_imm, ref_imm(m_instr));
        check("a.out_rs1", 32'(if_a.out_rs1), 32'(m_instr[19:15]));
        check("a.out_rs2", 32'(if_a.out_rs2), 32'(m_instr[24:20]));
        check("a.out_rd", 32'(if_a.out_rd), 32'(m_instr[11:7]));
        check("a.out_opcode", 32'(if_a.out_opcode), 32'(m_instr[6:0]));
        check("a.out_funct3", 32'(if_a.out_funct3), 32'(m_instr[14:12]));
        check("a.out_funct7", 32'(if_a.out_funct7), 32'(m_instr[31:25]));
        check("a.out_rs1_data", if_a.out_rs1_data, m_d1[0]);
        check("a.out_rs2_data", if_a.out_rs2_data, m_d2[0]);
        check("a.out_illegal", 32'(if_a.out_illegal), 32'(m_ill[0]));
        check("b.out_imm", if_b.out_imm, ref_imm(m_instr));
        check("b.out_rd", 32'(if_b.out_rd), 32'(m_instr[11:7]));
        check("b.out_rs1_data", if_b.out_rs1_data, m_d1[1]);
        check("b.out_rs2_data", if_b.out_rs2_data, m_d2[1]);
        check("b.out_illegal", 32'(if_b.out_illegal), 32'(m_ill[1]));
    endtask

    // One clock: check outputs mid-cycle, advance the model, return just
    // after the next rising edge so callers may drive new inputs.
    task automatic cycle();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] w;
        int          k;
        ops = '{OP_LOAD, OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH,
                OP_LUI, OP_AUIPC, OP_JAL, OP_REG};
        w = $urandom();
        k = $urandom_range(0, 10);
        w[6:0] = (k == 10) ? 7'($urandom()) : ops[k];
        if ($urandom_range(0, 7) != 0) begin
            w[11:7]  = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wb_we     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'h0;
        instr     = 32'h0;
        pc        = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // addi x1,x0,5
        in_valid = 1'b1;
        instr    = 32'h0050_0093;
        pc       = 32'h100;
        cycle();
        check("addi.valid", 32'(if_a.out_valid), 32'h1);
        check("addi.imm", if_a.out_imm, 32'h5);
        check("addi.rd", 32'(if_a.out_rd), 32'h1);
        check("addi.pc", if_a.out_pc, 32'h100);
        check("addi.rs1_data", if_a.out_rs1_data, 32'h0);
        in_valid = 1'b0;
        cycle();
        check("drain.valid", 32'(if_a.out_valid), 32'h0);

        // add x4,x3,x3 with x3 written by WB in the same cycle
        wb_we    = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        instr    = 32'h0031_8233;
        pc       = 32'h104;
        cycle();
        wb_we = 1'b0;
        check("byp.a_rs1", if_a.out_rs1_data, 32'hDEAD_BEEF);
        check("byp.a_rs2", if_a.out_rs2_data, 32'hDEAD_BEEF);
        check("byp.b_rs1", if_b.out_rs1_data, 32'h0);
        check("byp.b_rs2", if_b.out_rs2_data, 32'h0);

        // lw x5,0(x2) then add x6,x5,x1: one bubble
        instr = 32'h0001_2283;
        pc    = 32'h108;
        cycle();
        instr = 32'h0012_8333;
        pc    = 32'h10C;
        #1;
        check("lu.in_ready_low", 32'(if_a.in_ready), 32'h0);
        cycle();
        check("lu.bubble", 32'(if_a.out_valid), 32'h0);
        check("lu.in_ready_high", 32'(if_a.in_ready), 32'h1);
        cycle();
        check("lu.add_valid", 32'(if_a.out_valid), 32'h1);
        check("lu.add_rd", 32'(if_a.out_rd), 32'h6);

        // Backpressure: addi x7 held for 3 cycles while addi x8 waits
        instr = 32'h0070_0393;
        pc    = 32'h110;
        cycle();
        out_ready = 1'b0;
        instr     = 32'h0080_0413;
        pc        = 32'h114;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.in_ready", 32'(if_a.in_ready), 32'h0);
            cycle();
            check("stall.rd", 32'(if_a.out_rd), 32'h7);
            check("stall.pc", if_a.out_pc, 32'h110);
        end
        out_ready = 1'b1;
        cycle();
        check("release.rd", 32'(if_a.out_rd), 32'h8);

        // Flush drops both the held bundle and the incoming instruction
        instr = 32'h0090_0493;
        pc    = 32'h118;
        cycle();
        flush     = 1'b1;
        out_ready = 1'b0;
        instr     = 32'h00A0_0513;
        pc        = 32'h11C;
        #1;
        check("flush.in_ready", 32'(if_a.in_ready), 32'h1);
        cycle();
        check("flush.valid", 32'(if_a.out_valid), 32'h0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("flush.gone", 32'(if_a.out_rd), 32'h9);

        // Register range on the 16-register instance; unknown opcode
        in_valid = 1'b1;
        instr    = 32'h0008_80B3;
        cycle();
        check("rv32e.b_illegal", 32'(if_b.out_illegal), 32'h1);
        check("rv32e.b_rs1_data", if_b.out_rs1_data, 32'h0);
        check("rv32e.a_illegal", 32'(if_a.out_illegal), 32'h0);
        in_valid = 1'b0;
        wb_we    = 1'b1;
        wb_rd    = 5'd20;
        wb_data  = 32'h1234_5678;
        cycle();
        wb_we    = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h000A_05B3;
        cycle();
        check("x20.a_rs1_data", if_a.out_rs1_data, 32'h1234_5678);
        check("x20.b_rs1_data", if_b.out_rs1_data, 32'h0);
        instr = 32'hFFFF_FFFF;
        cycle();
        check("bad.a_illegal", 32'(if_a.out_illegal), 32'h1);
        check("bad.a_imm", if_a.out_imm, 32'h0);
        check("bad.b_illegal", 32'(if_b.out_illegal), 32'h1);
        in_valid = 1'b0;
        cycle();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 399) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            instr     = rand_instr();
            pc        = $urandom();
            wb_we     = ($urandom_range(0, 1) != 0);
            wb_rd     = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom());
            wb_data   = $urandom();
            cycle();
        end
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        wb_we    = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
